req_ack_responder: RTL

REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

---
 rtl/req_ack_pkg.sv | 26 ++
 rtl/req_ack_lat_cnt.sv | 38 +++
 rtl/req_ack_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and helpers for the req/ack responder: FSM states, latency limit and
// the lat_cfg-to-effective-latency mapping.
package req_ack_pkg;

  localparam int unsigned MAX_LAT_LIMIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // lat_cfg 0 and 1 both mean "next cycle"; larger requests are capped at max_lat.
  function automatic logic [1:0] eff_lat(input logic [1:0] cfg, input logic [1:0] max_lat);
    logic [1:0] l;
    if (cfg <= 2'd1) begin
      l = 2'd1;
    end else if (cfg > max_lat) begin
      l = max_lat;
    end else begin
      l = cfg;
    end
    return l;
  endfunction

endpackage

// File: rtl/req_ack_lat_cnt.sv
// Latency counter: counts edges since accept and flags when the requested latency or the
// hard deadline would be met by entering ACK at the next edge.
module req_ack_lat_cnt
  import req_ack_pkg::*;
#(
  parameter logic [1:0] MaxLat = 2'(MAX_LAT_LIMIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [1:0] i_target,
  output logic       o_target,
  output logic       o_deadline
);

  logic [1:0] r_cnt;
  logic [2:0] w_next_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else if (i_clear) begin
      r_cnt <= 2'd0;
    end else if (i_load) begin
      r_cnt <= 2'd1;
    end else if (i_en && (r_cnt != 2'd3)) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Latency the ack would have if the FSM entered ACK at the coming edge.
  assign w_next_lat = {1'b0, r_cnt} + 3'd1;
  assign o_target   = w_next_lat >= {1'b0, i_target};
  assign o_deadline = w_next_lat >= {1'b0, MaxLat};

endmodule

// File: rtl/req_ack_responder.sv
// Request/acknowledge responder with bounded latency and busy back-pressure.
// Define REQ_ACK_RESPONDER_ASSERT_EN to compile in the embedded protocol assertions.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [DW-1:0] req_data,
  input  logic [1:0]    lat_cfg,
  input  logic          busy,
  output logic          ack,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic [15:0]   ack_cnt
);

  localparam int unsigned MaxLatI = (MAX_LAT < 1) ? 1 :
                                    ((MAX_LAT > MAX_LAT_LIMIT) ? MAX_LAT_LIMIT : MAX_LAT);
  localparam logic [1:0] MaxLat = 2'(MaxLatI);

  state_e        r_state;
  logic [DW-1:0] r_data;
  logic [1:0]    r_lat;
  logic          r_ack;
  logic [DW-1:0] r_resp_data;
  logic          r_resp_err;
  logic [15:0]   r_ack_cnt;

  logic [1:0] w_lat;
  logic       w_accept;
  logic       w_accept_ack;
  logic       w_wait_ack;
  logic       w_target;
  logic       w_deadline;

  assign w_lat        = eff_lat(lat_cfg, MaxLat);
  assign w_accept     = ((r_state == IDLE) || (r_state == ACK)) && req;
  // The accept edge itself counts as latency 1, so a short, unstalled request acks at once.
  assign w_accept_ack = ((w_lat == 2'd1) && !busy) || (MaxLat == 2'd1);
  assign w_wait_ack   = (r_state == WAIT) && ((w_target && !busy) || w_deadline);

  req_ack_lat_cnt #(
    .MaxLat(MaxLat)
  ) u_lat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wait_ack),
    .i_load    (w_accept),
    .i_en      (r_state == WAIT),
    .i_target  (r_lat),
    .o_target  (w_target),
    .o_deadline(w_deadline)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_lat       <= 2'd1;
      r_ack       <= 1'b0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_ack_cnt   <= 16'd0;
    end else begin
      r_ack_cnt <= r_ack_cnt + {15'd0, r_ack};
      unique case (r_state)
        IDLE, ACK: begin
          if (req) begin
            r_data <= req_data;
            r_lat  <= w_lat;
            if (w_accept_ack) begin
              r_state     <= ACK;
              r_ack       <= 1'b1;
              r_resp_data <= req_data + DW'(1);
              r_resp_err  <= busy;
            end else begin
              r_state     <= WAIT;
              r_ack       <= 1'b0;
              r_resp_data <= '0;
              r_resp_err  <= 1'b0;
            end
          end else begin
            r_state     <= IDLE;
            r_ack       <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
          end
        end
        WAIT: begin
          if (w_wait_ack) begin
            r_state     <= ACK;
            r_ack       <= 1'b1;
            r_resp_data <= r_data + DW'(1);
            // Without busy the target is always met by the deadline, so busy marks a forced ack.
            r_resp_err  <= busy;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ack       <= 1'b0;
          r_resp_data <= '0;
          r_resp_err  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign resp_data = r_resp_data;
  assign resp_err  = r_resp_err;
  assign ack_cnt   = r_ack_cnt;

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
  a_req_ack: assert property (@(posedge clk) disable iff (!rst_n) req |-> ##[1:MaxLatI] ack)
    else $error("req not acknowledged within MAX_LAT cycles");

  a_ack_after_reset: assert property (@(posedge clk) $rose(rst_n) |-> !ack)
    else $error("ack high at the edge following reset release");

  a_err_with_ack: assert property (@(posedge clk) disable iff (!rst_n) resp_err |-> ack)
    else $error("resp_err asserted without ack");
`else
`endif

endmodule
